// File: rtl/xor_fold_pkg.sv
// Shared types, tag constants and the 16->8 fold used by the digest scheduler.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
package xor_fold_pkg;

  // Two-state packet FSM; values are pinned so legacy code comparing raw bits still works.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;

  function automatic logic [7:0] fold16(input logic [15:0] w);
    return w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/xor_fold_16to8.sv
// Combinational 16->8 XOR fold; kept as its own module so a gate-level netlist can replace it.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: word (16-bit in), folded (8-bit out = upper byte ^ lower byte).
module xor_fold_16to8
  import xor_fold_pkg::*;
(
  input  logic [15:0] word,
  output logic [7:0]  folded
);

  assign folded = fold16(word);

endmodule

// File: rtl/xor_fold_sched.sv
// Round-robin packet scheduler sharing one XOR-fold datapath between requesters A and B;
// emits per-packet digest, requester tag and saturating word count.
// Latency: digest registered one cycle after the last word is accepted; one word per cycle.
// Backpressure: both readies drop while a digest is held (out_valid & ~out_ready).
// Ports: clk, rst_n (sync, active-low); a_/b_ valid,data,last,ready word streams;
//        out_valid/out_ready handshake with out_digest, out_tag, out_cnt.
module xor_fold_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [15:0]      a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [15:0]      b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_digest,
  output logic             out_tag,
  output logic [CNT_W-1:0] out_cnt
);

  import xor_fold_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state;
  logic             owner;
  logic             rr_ptr;
  logic [7:0]       acc;
  logic [CNT_W-1:0] cnt;

  logic             stall;
  logic             grant;
  logic             sel;
  logic             can_take;
  logic             fire;
  logic [15:0]      word;
  logic             last;
  logic [7:0]       folded;
  logic [7:0]       acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign stall = out_valid & ~out_ready;

  // Contention goes to rr_ptr; otherwise whoever is valid (B only when B alone is valid).
  assign grant = (a_valid & b_valid) ? rr_ptr : b_valid;

  // Mid-packet the owner keeps the datapath regardless of what the other side does.
  assign sel = (state == BUSY) ? owner : grant;

  // Ready depends only on valids, FSM state, reset and output handshake, never on data.
  assign can_take = rst_n & ~stall & ((state == BUSY) | a_valid | b_valid);
  assign a_ready  = can_take & (sel == TAG_A);
  assign b_ready  = can_take & (sel == TAG_B);

  assign fire = (a_valid & a_ready) | (b_valid & b_ready);
  assign word = (sel == TAG_B) ? b_data : a_data;
  assign last = (sel == TAG_B) ? b_last : a_last;

  xor_fold_16to8 u_fold (
    .word   (word),
    .folded (folded)
  );

  // The first word of a packet restarts the accumulator and counter.
  assign acc_nxt = (state == IDLE) ? folded : (acc ^ folded);
  assign cnt_nxt = (state == IDLE) ? CNT_W'(1)
                 : (cnt == CNT_MAX) ? cnt : (cnt + CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= TAG_A;
      rr_ptr     <= TAG_A;
      acc        <= 8'h00;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_digest <= 8'h00;
      out_tag    <= 1'b0;
      out_cnt    <= '0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (fire) begin
        if (last) begin
          // A new emit overrides the clear above, allowing back-to-back digests.
          out_valid  <= 1'b1;
          out_digest <= acc_nxt;
          out_cnt    <= cnt_nxt;
          out_tag    <= sel;
          rr_ptr     <= ~sel;
          state      <= IDLE;
        end else begin
          acc   <= acc_nxt;
          cnt   <= cnt_nxt;
          owner <= sel;
          state <= BUSY;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_fold_sched.sv
module tb_xor_fold_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_last, b_valid, b_last, out_ready;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, out_valid, out_tag;
  logic [7:0]  out_digest;
  logic [7:0]  out_cnt;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  xor_fold_sched #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_last     (a_last),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_last     (b_last),
    .b_ready    (b_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digest (out_digest),
    .out_tag    (out_tag),
    .out_cnt    (out_cnt)
  );

  // One record per clock cycle: inputs driven after the falling edge, expectations
  // checked just before the next rising edge (outputs reflect earlier cycles).
  typedef struct {
    logic        rst_n;
    logic        av;
    logic [15:0] ad;
    logic        al;
    logic        bv;
    logic [15:0] bd;
    logic        bl;
    logic        ordy;
    logic        ea;
    logic        eb;
    logic        eov;
    logic        cd;   // compare digest/tag/cnt in this row
    logic [7:0]  ed;
    logic        et;
    logic [7:0]  ec;
  } vec_t;

  localparam int NV = 23;
  vec_t tv[NV];

  function automatic vec_t mk(logic r, logic av, logic [15:0] ad, logic al,
                              logic bv, logic [15:0] bd, logic bl, logic ordy,
                              logic ea, logic eb, logic eov, logic cd,
                              logic [7:0] ed, logic et, logic [7:0] ec);
    vec_t v;
    v.rst_n = r;  v.av = av; v.ad = ad; v.al = al;
    v.bv = bv;    v.bd = bd; v.bl = bl; v.ordy = ordy;
    v.ea = ea;    v.eb = eb; v.eov = eov; v.cd = cd;
    v.ed = ed;    v.et = et; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic av, input logic [15:0] ad, input logic al,
                       input logic bv, input logic [15:0] bd, input logic bl, input logic ordy);
    rst_n = r; a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl; out_ready = ordy;
  endtask

  initial begin
    //         rst av ad        al bv bd        bl ordy  ea eb ov cd dig    tag cnt
    // Simultaneous 1-word packets from reset: A first, then B, next contended round B first.
    tv[0]  = mk(1, 1, 16'hFF00, 1, 1, 16'h0F0F, 1, 1,    1, 0, 0, 1, 8'h00, 0, 8'd0);
    tv[1]  = mk(1, 1, 16'h00AA, 1, 1, 16'h0F0F, 1, 1,    0, 1, 1, 1, 8'hFF, 0, 8'd1);
    tv[2]  = mk(1, 1, 16'h00AA, 1, 0, 16'h0000, 0, 1,    1, 0, 1, 1, 8'h00, 1, 8'd1);
    // 2-word packet on A: 12^34 ^ AB^CD = 40.
    tv[3]  = mk(1, 1, 16'h1234, 0, 0, 16'h0000, 0, 1,    1, 0, 1, 1, 8'hAA, 0, 8'd1);
    tv[4]  = mk(1, 1, 16'hABCD, 1, 0, 16'h0000, 0, 1,    1, 0, 0, 0, 8'h00, 0, 8'd0);
    // 3-word A packet (digest 03^07^03 = 07) while B waits, B follows with no bubble.
    tv[5]  = mk(1, 1, 16'h0102, 0, 0, 16'h0000, 0, 1,    1, 0, 1, 1, 8'h40, 0, 8'd2);
    tv[6]  = mk(1, 1, 16'h0304, 0, 1, 16'h0F0F, 1, 1,    1, 0, 0, 0, 8'h00, 0, 8'd0);
    tv[7]  = mk(1, 1, 16'h0506, 1, 1, 16'h0F0F, 1, 1,    1, 0, 0, 0, 8'h00, 0, 8'd0);
    tv[8]  = mk(1, 0, 16'h0000, 0, 1, 16'h0F0F, 1, 1,    0, 1, 1, 1, 8'h07, 0, 8'd3);
    tv[9]  = mk(1, 1, 16'h1234, 1, 0, 16'h0000, 0, 1,    1, 0, 1, 1, 8'h00, 1, 8'd1);
    // Backpressure for 5 cycles, then release admits the waiting word in the same cycle.
    tv[10] = mk(1, 1, 16'h5678, 1, 0, 16'h0000, 0, 0,    0, 0, 1, 1, 8'h26, 0, 8'd1);
    tv[11] = mk(1, 1, 16'h5678, 1, 0, 16'h0000, 0, 0,    0, 0, 1, 1, 8'h26, 0, 8'd1);
    tv[12] = mk(1, 1, 16'h5678, 1, 0, 16'h0000, 0, 0,    0, 0, 1, 1, 8'h26, 0, 8'd1);
    tv[13] = mk(1, 1, 16'h5678, 1, 0, 16'h0000, 0, 0,    0, 0, 1, 1, 8'h26, 0, 8'd1);
    tv[14] = mk(1, 1, 16'h5678, 1, 0, 16'h0000, 0, 0,    0, 0, 1, 1, 8'h26, 0, 8'd1);
    tv[15] = mk(1, 1, 16'h5678, 1, 0, 16'h0000, 0, 1,    1, 0, 1, 1, 8'h26, 0, 8'd1);
    tv[16] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,    0, 0, 1, 1, 8'h2E, 0, 8'd1);
    // Reset after 2 words of a B packet; following A packet excludes those words.
    tv[17] = mk(1, 0, 16'h0000, 0, 1, 16'h1200, 0, 1,    0, 1, 0, 0, 8'h00, 0, 8'd0);
    tv[18] = mk(1, 0, 16'h0000, 0, 1, 16'h3400, 0, 1,    0, 1, 0, 0, 8'h00, 0, 8'd0);
    tv[19] = mk(0, 1, 16'h00FF, 0, 1, 16'h5600, 0, 1,    0, 0, 0, 0, 8'h00, 0, 8'd0);
    tv[20] = mk(1, 1, 16'h00FF, 0, 1, 16'h5600, 0, 1,    1, 0, 0, 1, 8'h00, 0, 8'd0);
    tv[21] = mk(1, 1, 16'h0001, 1, 1, 16'h5600, 0, 1,    1, 0, 0, 0, 8'h00, 0, 8'd0);
    tv[22] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,    0, 0, 1, 1, 8'hFE, 0, 8'd2);

    // Initial reset; readies must be low even with both requesters valid.
    drive(0, 1, 16'h1111, 1, 1, 16'h2222, 1, 1);
    repeat (3) @(negedge clk);
    #2;
    chk("reset_a_ready", 32'(a_ready), 32'd0);
    chk("reset_b_ready", 32'(b_ready), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].rst_n, tv[i].av, tv[i].ad, tv[i].al, tv[i].bv, tv[i].bd, tv[i].bl, tv[i].ordy);
      #2;
      chk($sformatf("r%0d_a_ready", i), 32'(a_ready), 32'(tv[i].ea));
      chk($sformatf("r%0d_b_ready", i), 32'(b_ready), 32'(tv[i].eb));
      chk($sformatf("r%0d_out_valid", i), 32'(out_valid), 32'(tv[i].eov));
      if (tv[i].cd) begin
        chk($sformatf("r%0d_digest", i), 32'(out_digest), 32'(tv[i].ed));
        chk($sformatf("r%0d_tag", i), 32'(out_tag), 32'(tv[i].et));
        chk($sformatf("r%0d_cnt", i), 32'(out_cnt), 32'(tv[i].ec));
      end
    end

    // Saturation: 300 words of 0101 fold to 00 each; count must stick at 255.
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      drive(1, 1, 16'h0101, (w == 299), 0, 16'h0000, 0, 1);
      #2;
      if (a_ready !== 1'b1) chk($sformatf("sat_w%0d_a_ready", w), 32'(a_ready), 32'd1);
    end
    @(negedge clk);
    drive(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
    #2;
    chk("sat_out_valid", 32'(out_valid), 32'd1);
    chk("sat_digest", 32'(out_digest), 32'h00);
    chk("sat_tag", 32'(out_tag), 32'd0);
    chk("sat_cnt", 32'(out_cnt), 32'd255);

    @(negedge clk);
    #2;
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
